half_stream_packer: RTL

Deserialiser that accepts a stream of half-precision elements, `LANES` per beat, and assembles them into `LENGTH`-element vectors for the parallel neural-network layer stages. It generalises the single-lane stream-to-vector stage with multi-lane beats, full valid/ready backpressure on both sides and a registered output slot. With `HALF_PACK_LAST_EN` defined, it also closes short vectors early and zero-pads them. It sits between serial producers (activation/readout streams) and vector-wide consumers (dot-product and layer blocks).

---
 rtl/half_pkg.sv | 15 +
 rtl/half_vec_slot.sv | 52 +++++
 rtl/half_stream_packer.sv | 113 +++++++++++
 3 files changed

// File: rtl/half_pkg.sv
// Shared types and helpers for the half-precision stream blocks.
package half_pkg;

  typedef logic [15:0] half_t;

  localparam half_t HALF_ZERO = 16'h0000;

  typedef enum logic {FILL0, FILLING} fill_st_e;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_st_e;

  function automatic int count_width(input int length);
    return $clog2(length + 1);
  endfunction

endpackage

// File: rtl/half_vec_slot.sv
// One-deep registered output slot with valid/ready handshake.
// A load in the same cycle as a drain reloads the slot without a bubble.
module half_vec_slot
  import half_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int LENGTH = 10,
  parameter int CW     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [LENGTH-1:0][BITS-1:0]  load_data,
  input  logic [CW-1:0]                load_count,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [LENGTH-1:0][BITS-1:0]  out_data,
  output logic [CW-1:0]                out_count
);

  slot_st_e st, st_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= SLOT_EMPTY;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      SLOT_EMPTY: if (load) st_nxt = SLOT_FULL;
      SLOT_FULL:  if (!load && out_ready) st_nxt = SLOT_EMPTY;
      default:    st_nxt = SLOT_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (st == SLOT_FULL);
  end

  // Payload only moves on load, so it stays stable while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_count <= '0;
    end else if (load) begin
      out_data  <= load_data;
      out_count <= load_count;
    end
  end

endmodule

// File: rtl/half_stream_packer.sv
// Packs LANES-wide half-precision beats into LENGTH-element vectors.
// Define HALF_PACK_LAST_EN to add in_last for early close with zero padding.
module half_stream_packer
  import half_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int LENGTH = 10,
  parameter int LANES  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][BITS-1:0]   in_data,
`ifdef HALF_PACK_LAST_EN
  input  logic                         in_last,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LENGTH-1:0][BITS-1:0]  out_data,
  output logic [$clog2(LENGTH+1)-1:0]  out_count
);

  localparam int BEATS = LENGTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = count_width(LENGTH);

  generate
    if (LENGTH % LANES != 0) begin : g_bad_lanes
      $error("half_stream_packer: LENGTH must be a multiple of LANES");
    end
  endgenerate

  logic [LENGTH-1:0][BITS-1:0] acc, merged;
  logic [BW-1:0]               beat;
  logic [CW-1:0]               load_count;
  logic                        last_beat, closing, slot_free;
  logic                        accept, acc_wr, load;
  fill_st_e                    st, st_nxt;

  assign last_beat = (beat == BW'(BEATS - 1));
  assign slot_free = !out_valid || out_ready;

`ifdef HALF_PACK_LAST_EN
  assign closing = last_beat || in_last;
`else
  assign closing = last_beat;
`endif

  // Current beat's lanes overlay acc; untouched elements are already zero.
  generate
    for (genvar j = 0; j < LENGTH; j++) begin : g_merge
      assign merged[j] = (beat == BW'(j / LANES)) ? in_data[j % LANES] : acc[j];
    end
  endgenerate

  assign load_count = CW'((32'(beat) + 32'd1) * LANES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= FILL0;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      FILL0:   if (accept && !closing) st_nxt = FILLING;
      FILLING: if (accept && closing)  st_nxt = FILL0;
      default: st_nxt = FILL0;
    endcase
  end

  always_comb begin
`ifdef HALF_PACK_LAST_EN
    in_ready = slot_free;
`else
    in_ready = !last_beat || slot_free;
`endif
    accept = in_valid && in_ready;
    acc_wr = accept && !closing;
    load   = accept && closing;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      beat <= '0;
    end else if (load) begin
      acc  <= '0;
      beat <= '0;
    end else if (acc_wr) begin
      acc  <= merged;
      beat <= beat + BW'(1);
    end
  end

  half_vec_slot #(
    .BITS   (BITS),
    .LENGTH (LENGTH),
    .CW     (CW)
  ) u_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (merged),
    .load_count (load_count),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count)
  );

endmodule
